cla_add_sequencer: RTL

Multi-cycle sequencer that performs a NIBBLES×4-bit addition using one shared external 4-bit CLA adder. It slices wide operands into nibbles and feeds them least-significant first, chaining the carry through an internal flip-flop. The wide result is assembled in a register. The block sits between a valid/ready operand source and a valid/ready result sink; the 4-bit CLA is instantiated alongside it, and its ports are wired to add_*.

---
 rtl/cla_add_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer: performs a (4*NIBBLES)-bit add one nibble at a time
// through a shared external 4-bit CLA. The slices go in least-significant
// first, and the carry is chained through carry_q between them.
module cla_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    // The index keeps at least one bit, so that NIBBLES=1 still gets a legal vector.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;

    logic            accept;
    logic            release_res;
    logic            last_nib;

    assign accept      = (state_q == IDLE) && in_valid && in_ready_q;
    assign release_res = (state_q == DONE) && out_valid_q && out_ready;
    assign last_nib    = (idx_q == IW'(NIBBLES - 1));

    // State and handshake flags are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic. The handshake flags follow directly from the state being entered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = RUN;
            RUN:     if (last_nib)    state_d = DONE;
            DONE:    if (release_res) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Drive the current nibble to the CLA while running, and zeros otherwise.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[4*idx_q +: 4];
            add_b   = b_q[4*idx_q +: 4];
            add_cin = carry_q;
        end
    end

    // Operand capture, then one nibble of result and its carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[4*idx_q +: 4] <= add_sum;
            carry_q             <= add_cout;
            idx_q               <= idx_q + 1'b1;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign busy      = (state_q != IDLE);

endmodule
